// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if -- request/result bundle between the execute stage and mdu_core.
//
// Signals:
//   start  1   one-cycle request qualifying op, A and B
//   op     4   operation code (NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO,
//              MADD, MADDU, MSUB)
//   A, B   32  forwarded rs / rt operand values
//   busy   1   multiply or divide in progress
//   HI, LO 32  architectural HI/LO registers
//
// Modports:
//   master -- pipeline side, drives the request and observes the results
//   slave  -- mdu_core side
// ---------------------------------------------------------------------------
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, output op, output A, output B,
                    input busy, input HI, input LO);
    modport slave  (input start, input op, input A, input B,
                    output busy, output HI, output LO);
endinterface

// File: rtl/mdu_core.sv
// ---------------------------------------------------------------------------
// mdu_core -- multi-cycle multiply/divide unit holding the HI/LO registers.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of mdu_if (start/op/A/B in, busy/HI/LO out)
//
// Multiply-class operations take 5 busy cycles and divide-class operations
// take 10. Operands are latched at start; the result is formed from the
// latched operands and written on the edge that ends the last busy cycle,
// so busy falls and the new HI/LO appear together. MTHI/MTLO write in a
// single edge without raising busy.
//
// Configuration macro MDU_MADD_EN: when defined, MADD/MADDU/MSUB
// (ops 7/8/9) accumulate into {HI,LO}; when undefined they act as NOP.
// ---------------------------------------------------------------------------
module mdu_core (
    input  logic  clk,
    input  logic  reset_n,
    mdu_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    localparam logic [3:0] MUL_LOAD = 4'd4;   // 5 cycles, counts 4..0
    localparam logic [3:0] DIV_LOAD = 4'd9;   // 10 cycles, counts 9..0

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
`ifdef MDU_MADD_EN
    logic [63:0] acc_q;
`endif

    logic        is_mul_s, is_div_s, is_mthi_s, is_mtlo_s;
    logic        accept_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s, rem_s;

    // Opcode decode of the incoming request.
    always_comb begin
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        is_mthi_s = 1'b0;
        is_mtlo_s = 1'b0;
        case (bus.op)
            4'd1, 4'd2: is_mul_s  = 1'b1;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9: is_mul_s = 1'b1;
`endif
            4'd3, 4'd4: is_div_s  = 1'b1;
            4'd5:       is_mthi_s = 1'b1;
            4'd6:       is_mtlo_s = 1'b1;
            default:    is_mul_s  = 1'b0;
        endcase
    end

    // A request is only honoured from IDLE; anything arriving while busy is dropped.
    assign accept_s = bus.start && (state_q == ST_IDLE);

    // FSM state and cycle counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state and counter load/decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = ST_MUL;
                    cnt_d   = MUL_LOAD;
                end else if (accept_s && is_div_s) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Operand capture on an accepted multiply or divide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= 4'd0;
        end else if (accept_s && (is_mul_s || is_div_s)) begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            op_q <= bus.op;
        end else begin
            a_q  <= a_q;
            b_q  <= b_q;
            op_q <= op_q;
        end
    end

`ifdef MDU_MADD_EN
    // Accumulator snapshot of {HI,LO} taken when a multiply starts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= 64'd0;
        end else if (accept_s && is_mul_s) begin
            acc_q <= {hi_q, lo_q};
        end else begin
            acc_q <= acc_q;
        end
    end
`endif

    // Arithmetic on the latched operands.
    // The 64-bit product of sign- or zero-extended operands is exact in its
    // low 64 bits for both signed and unsigned cases. Signed division works
    // on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        logic        mul_signed;
        logic        div_signed;
        logic [63:0] ext_a, ext_b;
        logic [31:0] a_mag, b_mag, q_mag, r_mag;

        mul_signed = (op_q == 4'd1) || (op_q == 4'd7) || (op_q == 4'd9);
        div_signed = (op_q == 4'd3);

        ext_a  = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b  = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod_s = ext_a * ext_b;

        a_mag = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        b_mag = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end else begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end
        quot_s = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
        rem_s  = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;
    end

    // FSM outputs: next HI/LO values (moves in IDLE, results on the final busy cycle).
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_mthi_s) begin
                    hi_d = bus.A;
                end else if (accept_s && is_mtlo_s) begin
                    lo_d = bus.A;
                end else begin
                    hi_d = hi_q;
                end
            end
            ST_MUL: begin
                if (cnt_q == 4'd0) begin
                    case (op_q)
`ifdef MDU_MADD_EN
                        4'd7, 4'd8: {hi_d, lo_d} = acc_q + prod_s;
                        4'd9:       {hi_d, lo_d} = acc_q - prod_s;
`endif
                        default:    {hi_d, lo_d} = prod_s;
                    endcase
                end else begin
                    hi_d = hi_q;
                end
            end
            ST_DIV: begin
                // A zero divisor burns the full latency but leaves HI/LO alone.
                if ((cnt_q == 4'd0) && (b_q != 32'd0)) begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end else begin
                    hi_d = hi_q;
                end
            end
            default: begin
                hi_d = hi_q;
            end
        endcase
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: doc/mdu_core.md
MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 start  input  1  one-cycle request qualifying op, A and B; driven from the E stage.
REQ-005 op  input  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB; 10-15 are NOP.
REQ-006 A, B  input  32 each  rs and rt operand values (already forwarded).
REQ-007 busy  output  1  high while a multiply or divide is in progress; consumed by the hazard unit with start.
REQ-008 HI, LO  output  32 each  architectural HI/LO registers, read directly by MFHI/MFLO.

Function
REQ-009 A start with op in {1,2,3,4,7,8,9} sampled while busy=0 SHALL latch A, B and op on that edge.
REQ-010 busy SHALL be high for exactly 5 cycles after a multiply-class start (ops 1,2,7,8,9) and for exactly 10 cycles after a divide-class start (ops 3,4).
REQ-011 A start sampled at edge k SHALL give busy high in cycles k+1..k+N, with HI/LO written on the edge that ends cycle k+N; the new values SHALL be visible in the same cycle busy falls.
REQ-012 HI and LO SHALL NOT change while busy=1.
REQ-013 MULT SHALL produce the signed 64-bit product {HI,LO}; MULTU SHALL produce the unsigned 64-bit product.
REQ-014 DIV SHALL set LO to the signed quotient truncated toward zero and HI to the remainder, with the remainder taking the sign of the dividend.
REQ-015 DIVU SHALL set LO to the unsigned quotient and HI to the unsigned remainder.
REQ-016 For DIV or DIVU with B=0, the block SHALL keep busy for the full 10 cycles and leave HI and LO unchanged.
REQ-017 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-018 MTHI or MTLO with start=1 and busy=0 SHALL write A into HI or LO on that edge; busy SHALL stay 0.
REQ-019 Any start sampled while busy=1 SHALL be ignored; the hazard unit guarantees this never occurs, and the bench SHALL flag it.
REQ-020 A start with a NOP op (0 or 10-15) SHALL have no effect.
REQ-021 The cycle count SHALL be a down-counter loaded with N-1 at start; busy SHALL be low on the edge after the counter reaches 0.
REQ-022 The block SHALL use a three-state FSM: IDLE, MUL, DIV. A valid start moves IDLE to MUL or DIV; counter=0 moves MUL or DIV back to IDLE.

Reset
REQ-023 With reset_n=0 at a clk edge, the block SHALL set HI=0, LO=0 and busy=0, clear the counter and return the FSM to IDLE.
REQ-024 Reset during an operation SHALL abort it, and the aborted operation SHALL never write HI or LO.
REQ-025 When reset_n=0 and start=1 at the same edge, reset SHALL take priority.

Configuration
REQ-026 Macro MDU_MADD_EN defined: ops 7, 8 and 9 SHALL be supported.
- MADD: {HI,LO} += signed A*B.
- MADDU: {HI,LO} += unsigned A*B.
- MSUB: {HI,LO} -= signed A*B.
- All three use 64-bit wrap-around arithmetic, the {HI,LO} operand is captured at start, and latency is 5 cycles.
REQ-027 Macro MDU_MADD_EN undefined: ops 7, 8 and 9 SHALL be treated as NOP, with busy staying 0 and HI/LO unchanged.

Verification
REQ-028 MULT with A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 DIV with A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=0 -> HI and LO unchanged.
REQ-030 MTLO with A=0x12345678 -> LO=0x12345678 on the next edge; busy=0 throughout.
REQ-031 MULTU with A=B=0xFFFFFFFF, then reset_n=0 in busy cycle 3 -> HI=0, LO=0 and busy=0 after that edge; no later write occurs.
REQ-032 Back-to-back test: start DIVU (A=100, B=7) in the cycle busy falls after a MULT -> busy stays low for one cycle, then is high for 10 cycles; then LO=14, HI=2.
REQ-033 With MDU_MADD_EN defined, HI=0, LO=5, then MADD with A=2, B=3 -> LO=11, HI=0. Without the macro -> LO stays 5 and busy never rises.
